pps_encoder: RTL and testbench

PPS encoder that serialises qp, tiles_enabled and the tile grid into a PPS RBSP bit buffer, one bit per clock, MSB-first. It produces the same field order and coding as the header decoder path: u(6) qp, u(1) tiles_enabled, then, when tiles are enabled, ue(v) num_tile_columns_minus1 and ue(v) num_tile_rows_minus1. It sits in the camera header generation path, ahead of the NAL packer.

---
 rtl/pps_encoder.sv | 163 ++++++++++++++++
 tb/tb_pps_encoder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pps_encoder.sv
// PPS RBSP bit serialiser: u(6) qp, u(1) tiles_enabled, then ue(v) tile columns/rows
// when tiles are on, written MSB-first one bit per clock into a packed buffer.
module pps_encoder #(
    parameter int BUF_W     = 3072,
    parameter int MAX_TILES = 16,
    parameter int MAX_QP    = 51
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       qp,
    input  logic             tiles_enabled,
    input  logic [4:0]       tile_cols,
    input  logic [4:0]       tile_rows,
    output logic [BUF_W-1:0] pps_bitstream,
    output logic [11:0]      bit_count,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {IDLE, QP, TILES, COLS, ROWS, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        tiles_q;
    logic [4:0]  cols_q;
    logic [4:0]  rows_q;
    logic [8:0]  code_q;
    logic [3:0]  cnt_q;

    logic        accept;
    logic        illegal;
    logic        emit;
    logic        load;
    logic [8:0]  load_code;
    logic [3:0]  load_cnt;
    logic [11:0] wr_idx;

    // ue(v) of count-1 has m = count, so the field is m in 2*floor(log2 m)+1 bits;
    // returns that length minus one, i.e. the starting field-bit index.
    function automatic logic [3:0] ue_top(input logic [4:0] m);
        logic [3:0] top;
        casez (m)
            5'b1????: top = 4'd8;
            5'b01???: top = 4'd6;
            5'b001??: top = 4'd4;
            5'b0001?: top = 4'd2;
            default:  top = 4'd0;
        endcase
        return top;
    endfunction

    assign illegal = (qp > 6'(MAX_QP)) ||
                     (tiles_enabled && ((tile_cols == 5'd0) || (tile_cols > 5'(MAX_TILES)) ||
                                        (tile_rows == 5'd0) || (tile_rows > 5'(MAX_TILES))));

    assign wr_idx = 12'(BUF_W - 1) - bit_count;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        emit      = 1'b0;
        load      = 1'b0;
        load_code = '0;
        load_cnt  = '0;
        case (state)
            IDLE: begin
                // busy is a registered view of the state, so it also guards the cycle after DONE
                if (start && !busy) begin
                    accept = 1'b1;
                    if (illegal) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = QP;
                        load      = 1'b1;
                        load_code = {3'b000, qp};
                        load_cnt  = 4'd5;
                    end
                end
            end
            QP: begin
                emit = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_nxt = TILES;
                    load      = 1'b1;
                    load_code = {8'd0, tiles_q};
                    load_cnt  = 4'd0;
                end
            end
            TILES: begin
                emit = 1'b1;
                if (tiles_q) begin
                    state_nxt = COLS;
                    load      = 1'b1;
                    load_code = {4'd0, cols_q};
                    load_cnt  = ue_top(cols_q);
                end else begin
                    state_nxt = DONE;
                end
            end
            COLS: begin
                emit = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_nxt = ROWS;
                    load      = 1'b1;
                    load_code = {4'd0, rows_q};
                    load_cnt  = ue_top(rows_q);
                end
            end
            ROWS: begin
                emit = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            tiles_q       <= 1'b0;
            cols_q        <= '0;
            rows_q        <= '0;
            code_q        <= '0;
            cnt_q         <= '0;
            pps_bitstream <= '0;
            bit_count     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state != IDLE);
            done  <= (state == DONE);
            if (accept) begin
                tiles_q       <= tiles_enabled;
                cols_q        <= tile_cols;
                rows_q        <= tile_rows;
                pps_bitstream <= '0;
                bit_count     <= '0;
                error         <= illegal;
            end
            if (emit) begin
                pps_bitstream[wr_idx] <= code_q[cnt_q];
                bit_count             <= bit_count + 12'd1;
                cnt_q                 <= cnt_q - 4'd1;
            end
            if (load) begin
                code_q <= load_code;
                cnt_q  <= load_cnt;
            end
        end
    end

endmodule

// File: tb/tb_pps_encoder.sv
// Self-checking bench for pps_encoder: directed plan cases plus randomized
// parameters against a bit-list reference model of the PPS field coding.
module tb_pps_encoder;

    localparam int BUF_W = 3072;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [5:0]       qp = '0;
    logic             tiles_enabled = 1'b0;
    logic [4:0]       tile_cols = '0;
    logic [4:0]       tile_rows = '0;
    logic [BUF_W-1:0] pps_bitstream;
    logic [11:0]      bit_count;
    logic             busy;
    logic             done;
    logic             error;

    int checks = 0;
    int errors = 0;

    pps_encoder #(.BUF_W(BUF_W), .MAX_TILES(16), .MAX_QP(51)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .qp(qp),
        .tiles_enabled(tiles_enabled),
        .tile_cols(tile_cols),
        .tile_rows(tile_rows),
        .pps_bitstream(pps_bitstream),
        .bit_count(bit_count),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: list of stream bits built from the field rules, then packed from the MSB.
    task automatic buildModel(input int q, input int te, input int c, input int r,
                              output logic [BUF_W-1:0] exp_buf, output int n, output bit err);
        bit bits[$];
        int vals[2];
        err = (q > 51) || ((te != 0) && (c < 1 || c > 16 || r < 1 || r > 16));
        exp_buf = '0;
        n = 0;
        if (!err) begin
            for (int i = 5; i >= 0; i--) bits.push_back(bit'((q >> i) & 1));
            bits.push_back(bit'(te));
            if (te != 0) begin
                vals[0] = c;
                vals[1] = r;
                foreach (vals[j]) begin
                    int m;
                    int l;
                    m = (vals[j] - 1) + 1;
                    l = 0;
                    while ((1 << (l + 1)) <= m) l++;
                    for (int z = 0; z < l; z++) bits.push_back(1'b0);
                    for (int i = l; i >= 0; i--) bits.push_back(bit'((m >> i) & 1));
                end
            end
            n = bits.size();
            foreach (bits[i]) exp_buf[BUF_W-1-i] = bits[i];
        end
    endtask

    task automatic applyStimulus(input int q, input int te, input int c, input int r, input bit hold);
        logic [BUF_W-1:0] exp_buf;
        int n;
        bit err;
        buildModel(q, te, c, r, exp_buf, n, err);
        @(negedge clk);
        qp = 6'(q);
        tiles_enabled = 1'(te);
        tile_cols = 5'(c);
        tile_rows = 5'(r);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        checkOutput("error_at_accept", 32'(error), 32'(err));
        for (int k = 1; k <= n + 2; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bit_count@%0d", k), 32'(bit_count), 32'((k < n) ? k : n));
            checkOutput($sformatf("done@%0d", k), 32'(done), 32'(k == n + 1));
            checkOutput($sformatf("busy@%0d", k), 32'(busy), 32'(k <= n + 1));
            if (k == n + 1) checkOutput("error_with_done", 32'(error), 32'(err));
        end
        start = 1'b0;
        checkOutput("buf_hi", pps_bitstream[BUF_W-1 -: 32], exp_buf[BUF_W-1 -: 32]);
        checkOutput("buf_lo_zero", 32'(|pps_bitstream[BUF_W-33:0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("held_count", 32'(bit_count), 32'(n));
        checkOutput("held_error", 32'(error), 32'(err));
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_buf", 32'(|pps_bitstream), 32'd0);
        checkOutput("reset_count", 32'(bit_count), 32'd0);
        checkOutput("reset_flags", {29'd0, busy, done, error}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);

        applyStimulus(26, 0, 0, 0, 1'b0);
        checkOutput("case1_bits", 32'(pps_bitstream[BUF_W-1 -: 7]), 32'(7'b0110100));
        applyStimulus(30, 1, 4, 2, 1'b0);
        checkOutput("case2_bits", 32'(pps_bitstream[BUF_W-1 -: 15]), 32'(15'b011110100100010));
        applyStimulus(0, 1, 1, 16, 1'b0);
        checkOutput("case3_bits", 32'(pps_bitstream[BUF_W-1 -: 17]), 32'(17'b00000011000010000));

        applyStimulus(52, 0, 0, 0, 1'b0);
        applyStimulus(10, 1, 17, 3, 1'b0);
        applyStimulus(10, 0, 0, 0, 1'b0);

        applyStimulus(30, 1, 4, 2, 1'b1);
        applyStimulus(63, 1, 0, 0, 1'b0);
        applyStimulus(26, 0, 0, 0, 1'b0);

        // Abort case 2 after eight bits with an asynchronous reset between clock edges.
        @(negedge clk);
        qp = 6'd30;
        tiles_enabled = 1'b1;
        tile_cols = 5'd4;
        tile_rows = 5'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        checkOutput("pre_abort_count", 32'(bit_count), 32'd8);
        reset = 1'b0;
        #1;
        checkOutput("abort_buf", 32'(|pps_bitstream), 32'd0);
        checkOutput("abort_count", 32'(bit_count), 32'd0);
        checkOutput("abort_flags", {29'd0, busy, done, error}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(26, 0, 0, 0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            applyStimulus(int'($urandom_range(0, 55)), int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 18)), int'($urandom_range(0, 18)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
